// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one block-wide main memory between the icache and dcache.
// The winner's address, write data and direction are latched for the whole transfer.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 28,
  parameter int BLOCK_WIDTH = 128
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   I_READ,
  input  logic [ADDR_WIDTH-1:0]  I_ADDRESS,
  output logic [BLOCK_WIDTH-1:0] I_READDATA,
  output logic                   I_BUSYWAIT,
  input  logic                   D_READ,
  input  logic                   D_WRITE,
  input  logic [ADDR_WIDTH-1:0]  D_ADDRESS,
  input  logic [BLOCK_WIDTH-1:0] D_WRITEDATA,
  output logic [BLOCK_WIDTH-1:0] D_READDATA,
  output logic                   D_BUSYWAIT,
  output logic                   MEM_READ,
  output logic                   MEM_WRITE,
  output logic [ADDR_WIDTH-1:0]  MEM_ADDRESS,
  output logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_WIDTH-1:0] MEM_READDATA,
  input  logic                   MEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t                 state_reg, state_next;
  logic                   last_grant_d_reg, last_grant_d_next;
  logic                   seen_busy_reg, seen_busy_next;
  logic [ADDR_WIDTH-1:0]  lat_addr_reg, lat_addr_next;
  logic [BLOCK_WIDTH-1:0] lat_wdata_reg, lat_wdata_next;
  logic                   lat_write_reg, lat_write_next;

  logic i_req, d_req, in_grant, complete;

  assign i_req    = I_READ;
  assign d_req    = D_READ | D_WRITE;
  assign in_grant = (state_reg != IDLE);
  // Memory must have been seen busy at least once before a low busywait means "done".
  assign complete = in_grant & seen_busy_reg & ~MEM_BUSYWAIT;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg        <= IDLE;
      last_grant_d_reg <= 1'b0;
      seen_busy_reg    <= 1'b0;
      lat_addr_reg     <= '0;
      lat_wdata_reg    <= '0;
      lat_write_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      last_grant_d_reg <= last_grant_d_next;
      seen_busy_reg    <= seen_busy_next;
      lat_addr_reg     <= lat_addr_next;
      lat_wdata_reg    <= lat_wdata_next;
      lat_write_reg    <= lat_write_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    last_grant_d_next = last_grant_d_reg;
    seen_busy_next    = seen_busy_reg;
    lat_addr_next     = lat_addr_reg;
    lat_wdata_next    = lat_wdata_reg;
    lat_write_next    = lat_write_reg;
    case (state_reg)
      IDLE: begin
        // On contention the dcache wins unless it was the one served last.
        if (d_req && (!i_req || !last_grant_d_reg)) begin
          state_next        = GRANT_D;
          last_grant_d_next = 1'b1;
          seen_busy_next    = 1'b0;
          lat_addr_next     = D_ADDRESS;
          lat_wdata_next    = D_WRITEDATA;
          lat_write_next    = D_WRITE;
        end else if (i_req) begin
          state_next        = GRANT_I;
          last_grant_d_next = 1'b0;
          seen_busy_next    = 1'b0;
          lat_addr_next     = I_ADDRESS;
          lat_wdata_next    = '0;
          lat_write_next    = 1'b0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (MEM_BUSYWAIT) seen_busy_next = 1'b1;
        if (complete) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign MEM_READ      = in_grant & ~lat_write_reg;
  assign MEM_WRITE     = in_grant & lat_write_reg;
  assign MEM_ADDRESS   = lat_addr_reg;
  assign MEM_WRITEDATA = lat_wdata_reg;

  assign I_BUSYWAIT = i_req & ~((state_reg == GRANT_I) & complete);
  assign D_BUSYWAIT = d_req & ~((state_reg == GRANT_D) & complete);

  assign I_READDATA = ((state_reg == GRANT_I) && complete) ? MEM_READDATA : '0;
  assign D_READDATA = ((state_reg == GRANT_D) && complete && !lat_write_reg) ? MEM_READDATA : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of round-robin arbitration and block memory.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int BW = 128;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          I_READ, D_READ, D_WRITE;
  logic [AW-1:0] I_ADDRESS, D_ADDRESS, MEM_ADDRESS;
  logic [BW-1:0] I_READDATA, D_READDATA, D_WRITEDATA, MEM_WRITEDATA, MEM_READDATA;
  logic          I_BUSYWAIT, D_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;

  int n_cmp = 0;
  int n_bad = 0;
  int fixed_lat = 3;

  logic [BW-1:0] gold [0:255];
  logic [BW-1:0] mem_store [0:255];
  bit   [255:0]  mem_written;
  int            mem_cnt;
  int            mem_lat;
  logic [7:0]    mem_idx;

  function automatic logic [BW-1:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 128'hDEADBEEF_00000001_00000002_00000003;
    return {4{a, 8'h3C, ~a, 8'hC3}};
  endfunction

  mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Main memory: busy for mem_lat cycles from the first strobed cycle, then done.
  assign mem_idx      = MEM_ADDRESS[7:0];
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < mem_lat);
  assign MEM_READDATA = mem_written[mem_idx] ? mem_store[mem_idx] : init_val(mem_idx);

  always @(posedge CLK) begin
    if (MEM_READ | MEM_WRITE) begin
      if (MEM_WRITE && !MEM_BUSYWAIT) begin
        mem_store[mem_idx]   <= MEM_WRITEDATA;
        mem_written[mem_idx] <= 1'b1;
      end
      mem_cnt <= mem_cnt + 1;
    end else begin
      mem_cnt <= 0;
      mem_lat <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
    end
  end

  task automatic idle_inputs();
    I_READ = 0; I_ADDRESS = '0; D_READ = 0; D_WRITE = 0; D_ADDRESS = '0; D_WRITEDATA = '0;
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #1; idle_inputs(); RESET = 0;
    @(posedge CLK); #1; RESET = 1;
  endtask

  task automatic test_reset();
    idle_inputs(); RESET = 0;
    @(posedge CLK); #1; RESET = 1;
    @(negedge CLK);
    n_cmp++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin n_bad++;
      $display("FAIL reset_strobes: got read=%b write=%b, expected 0 0", MEM_READ, MEM_WRITE); end
    n_cmp++; if (I_BUSYWAIT !== 1'b0 || D_BUSYWAIT !== 1'b0) begin n_bad++;
      $display("FAIL reset_busywait: got i=%b d=%b, expected 0 0", I_BUSYWAIT, D_BUSYWAIT); end
    n_cmp++; if (MEM_ADDRESS !== '0 || MEM_WRITEDATA !== '0) begin n_bad++;
      $display("FAIL reset_latches: got addr=%h wdata=%h, expected 0", MEM_ADDRESS, MEM_WRITEDATA); end
    n_cmp++; if (I_READDATA !== '0 || D_READDATA !== '0) begin n_bad++;
      $display("FAIL reset_readdata: got i=%h d=%h, expected 0", I_READDATA, D_READDATA); end
  endtask

  task automatic test_single_read();
    logic exp_bw;
    logic [BW-1:0] exp_rd;
    fixed_lat = 3;
    @(posedge CLK); #1; I_READ = 1; I_ADDRESS = 28'h0000010;
    @(negedge CLK);
    n_cmp++; if (I_BUSYWAIT !== 1'b1 || MEM_READ !== 1'b0) begin n_bad++;
      $display("FAIL single_req_cycle: got bw=%b read=%b, expected 1 0", I_BUSYWAIT, MEM_READ); end
    for (int c = 1; c <= 4; c++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      exp_bw = (c < 4);
      exp_rd = (c == 4) ? gold[8'h10] : '0;
      n_cmp++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 28'h0000010) begin n_bad++;
        $display("FAIL single_mem c%0d: got read=%b addr=%h, expected 1 0000010", c, MEM_READ, MEM_ADDRESS); end
      n_cmp++; if (I_BUSYWAIT !== exp_bw) begin n_bad++;
        $display("FAIL single_busywait c%0d: got %b expected %b", c, I_BUSYWAIT, exp_bw); end
      n_cmp++; if (I_READDATA !== exp_rd) begin n_bad++;
        $display("FAIL single_readdata c%0d: got %h expected %h", c, I_READDATA, exp_rd); end
    end
    @(posedge CLK); #1; I_READ = 0;
    @(negedge CLK);
    n_cmp++; if (MEM_READ !== 1'b0 || I_BUSYWAIT !== 1'b0) begin n_bad++;
      $display("FAIL single_after: got read=%b bw=%b, expected 0 0", MEM_READ, I_BUSYWAIT); end
  endtask

  task automatic test_contend();
    logic exp_w, exp_r, exp_ibw, exp_dbw;
    logic [BW-1:0] pat, exp_ird;
    pat = {16{8'hA5}};
    pulse_reset();
    fixed_lat = 2;
    @(posedge CLK); #1;
    D_WRITE = 1; D_ADDRESS = 28'h0000020; D_WRITEDATA = pat;
    I_READ = 1; I_ADDRESS = 28'h0000030;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) begin @(posedge CLK); #1; end
      if (c == 4) D_WRITE = 0;
      if (c == 8) I_READ = 0;
      @(negedge CLK);
      exp_w = (c >= 1 && c <= 3);
      exp_r = (c >= 5 && c <= 7);
      exp_dbw = (c <= 2);
      exp_ibw = (c <= 6);
      exp_ird = (c == 7) ? gold[8'h30] : '0;
      n_cmp++; if (MEM_WRITE !== exp_w || MEM_READ !== exp_r) begin n_bad++;
        $display("FAIL contend_strobes c%0d: got w=%b r=%b, expected %b %b", c, MEM_WRITE, MEM_READ, exp_w, exp_r); end
      n_cmp++; if (I_BUSYWAIT !== exp_ibw || D_BUSYWAIT !== exp_dbw) begin n_bad++;
        $display("FAIL contend_busywait c%0d: got i=%b d=%b, expected %b %b", c, I_BUSYWAIT, D_BUSYWAIT, exp_ibw, exp_dbw); end
      if (exp_w) begin
        n_cmp++; if (MEM_ADDRESS !== 28'h0000020 || MEM_WRITEDATA !== pat) begin n_bad++;
          $display("FAIL contend_dwrite c%0d: got addr=%h data=%h", c, MEM_ADDRESS, MEM_WRITEDATA); end
      end
      if (exp_r) begin
        n_cmp++; if (MEM_ADDRESS !== 28'h0000030) begin n_bad++;
          $display("FAIL contend_iaddr c%0d: got %h expected 0000030", c, MEM_ADDRESS); end
      end
      n_cmp++; if (I_READDATA !== exp_ird || D_READDATA !== '0) begin n_bad++;
        $display("FAIL contend_readdata c%0d: got i=%h d=%h, expected i=%h d=0", c, I_READDATA, D_READDATA, exp_ird); end
    end
    n_cmp++; if (!mem_written[8'h20] || mem_store[8'h20] !== pat) begin n_bad++;
      $display("FAIL contend_memwrite: got %h expected %h", mem_store[8'h20], pat); end
    gold[8'h20] = pat;
  endtask

  task automatic test_alternation();
    int  done, cyc;
    bit  i_fin, d_fin, exp_d;
    fixed_lat = 0;
    done = 0; cyc = 0;
    @(posedge CLK); #1;
    I_READ = 1; I_ADDRESS = 28'h0000040; D_READ = 1; D_WRITE = 0; D_ADDRESS = 28'h0000050;
    while (done < 4 && cyc < 200) begin
      @(negedge CLK); cyc++;
      i_fin = I_READ && (I_BUSYWAIT === 1'b0);
      d_fin = D_READ && (D_BUSYWAIT === 1'b0);
      if (i_fin || d_fin) begin
        exp_d = (done % 2 == 0);
        n_cmp++; if (d_fin !== exp_d || i_fin === d_fin) begin n_bad++;
          $display("FAIL alt_order #%0d: got d=%b i=%b, expected d=%b", done, d_fin, i_fin, exp_d); end
        n_cmp++; if ((d_fin && D_READDATA !== gold[8'h50]) || (i_fin && I_READDATA !== gold[8'h40])) begin n_bad++;
          $display("FAIL alt_readdata #%0d: got i=%h d=%h", done, I_READDATA, D_READDATA); end
        done++;
      end
      @(posedge CLK); #1;
      I_READ = i_fin ? 1'b0 : 1'b1;
      D_READ = d_fin ? 1'b0 : 1'b1;
    end
    n_cmp++; if (done < 4) begin n_bad++;
      $display("FAIL alt_timeout: got %0d transfers, expected 4", done); end
    idle_inputs();
    @(posedge CLK); #1;
  endtask

  task automatic test_addr_hold();
    int cyc;
    bit done;
    fixed_lat = 4;
    cyc = 0; done = 0;
    @(posedge CLK); #1; I_READ = 1; I_ADDRESS = 28'h0000010;
    @(negedge CLK);
    while (!done && cyc < 20) begin
      @(posedge CLK); #1; I_ADDRESS = 28'h0000FFF; cyc++;
      @(negedge CLK);
      n_cmp++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 28'h0000010) begin n_bad++;
        $display("FAIL hold_addr c%0d: got read=%b addr=%h, expected 1 0000010", cyc, MEM_READ, MEM_ADDRESS); end
      if (I_BUSYWAIT === 1'b0) begin
        done = 1;
        n_cmp++; if (I_READDATA !== gold[8'h10]) begin n_bad++;
          $display("FAIL hold_readdata: got %h expected %h", I_READDATA, gold[8'h10]); end
      end
    end
    n_cmp++; if (cyc !== 5) begin n_bad++;
      $display("FAIL hold_latency: got %0d cycles expected 5", cyc); end
    @(posedge CLK); #1; I_READ = 0; I_ADDRESS = '0;
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] pat;
    int cyc;
    pat = {$urandom, $urandom, $urandom, $urandom};
    fixed_lat = 10;
    @(posedge CLK); #1; D_WRITE = 1; D_ADDRESS = 28'h0000060; D_WRITEDATA = pat;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    n_cmp++; if (MEM_WRITE !== 1'b1 || MEM_ADDRESS !== 28'h0000060) begin n_bad++;
      $display("FAIL rmid_grant: got w=%b addr=%h, expected 1 0000060", MEM_WRITE, MEM_ADDRESS); end
    @(posedge CLK); #1; RESET = 0; D_WRITE = 0;
    @(posedge CLK); #1; RESET = 1; fixed_lat = 2;
    @(negedge CLK);
    n_cmp++; if (MEM_WRITE !== 1'b0 || MEM_READ !== 1'b0 || D_BUSYWAIT !== 1'b0) begin n_bad++;
      $display("FAIL rmid_abort: got w=%b r=%b dbw=%b, expected 0 0 0", MEM_WRITE, MEM_READ, D_BUSYWAIT); end
    n_cmp++; if (MEM_ADDRESS !== '0 || MEM_WRITEDATA !== '0) begin n_bad++;
      $display("FAIL rmid_latches: got addr=%h wdata=%h, expected 0", MEM_ADDRESS, MEM_WRITEDATA); end
    @(posedge CLK); #1; D_WRITE = 1; I_READ = 1; I_ADDRESS = 28'h0000070;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    n_cmp++; if (MEM_WRITE !== 1'b1 || MEM_READ !== 1'b0 || MEM_ADDRESS !== 28'h0000060 || MEM_WRITEDATA !== pat) begin n_bad++;
      $display("FAIL rmid_dfirst: got w=%b r=%b addr=%h data=%h", MEM_WRITE, MEM_READ, MEM_ADDRESS, MEM_WRITEDATA); end
    cyc = 0;
    while (D_BUSYWAIT === 1'b1 && cyc < 20) begin @(posedge CLK); #1; @(negedge CLK); cyc++; end
    n_cmp++; if (D_BUSYWAIT !== 1'b0 || I_BUSYWAIT !== 1'b1) begin n_bad++;
      $display("FAIL rmid_dcomplete: got dbw=%b ibw=%b, expected 0 1", D_BUSYWAIT, I_BUSYWAIT); end
    @(posedge CLK); #1; D_WRITE = 0;
    @(negedge CLK);
    cyc = 0;
    while (I_BUSYWAIT === 1'b1 && cyc < 20) begin @(posedge CLK); #1; @(negedge CLK); cyc++; end
    n_cmp++; if (I_BUSYWAIT !== 1'b0 || I_READDATA !== gold[8'h70]) begin n_bad++;
      $display("FAIL rmid_iread: got bw=%b data=%h expected 0 %h", I_BUSYWAIT, I_READDATA, gold[8'h70]); end
    @(posedge CLK); #1; I_READ = 0;
    n_cmp++; if (!mem_written[8'h60] || mem_store[8'h60] !== pat) begin n_bad++;
      $display("FAIL rmid_memwrite: got %h expected %h", mem_store[8'h60], pat); end
    gold[8'h60] = pat;
  endtask

  task automatic test_random();
    bit ia, da, dw, model_idle, last_d, own_d, cur_i, cur_d, complete;
    logic [AW-1:0] ia_addr, da_addr;
    logic [BW-1:0] dwd, exp_rd;
    int igap, dgap, xfers, cyc;
    fixed_lat = 0;
    pulse_reset();
    model_idle = 1; last_d = 0; own_d = 0; ia = 0; da = 0; dw = 0;
    ia_addr = '0; da_addr = '0; dwd = '0; igap = 0; dgap = 0; xfers = 0; cyc = 0;
    while (xfers < 60 && cyc < 3000) begin
      @(posedge CLK); #1; cyc++;
      if (!ia) begin
        if (igap > 0) igap--;
        else if ($urandom_range(0, 2) == 0) begin ia = 1; ia_addr = AW'($urandom_range(0, 255)); end
      end
      if (!da) begin
        if (dgap > 0) dgap--;
        else if ($urandom_range(0, 2) == 0) begin
          da = 1; da_addr = AW'($urandom_range(0, 255)); dw = 1'($urandom_range(0, 1));
          dwd = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      // Once a requester owns the memory its inputs may wander without effect.
      I_READ    = ia;
      I_ADDRESS = (!model_idle && !own_d && $urandom_range(0, 1) == 1) ? AW'($urandom) : ia_addr;
      D_WRITE   = da && dw;
      D_READ    = da && (!dw || $urandom_range(0, 1) == 1);
      D_ADDRESS = (!model_idle && own_d && $urandom_range(0, 1) == 1) ? AW'($urandom) : da_addr;
      D_WRITEDATA = (!model_idle && own_d && $urandom_range(0, 1) == 1) ? {$urandom, $urandom, $urandom, $urandom} : dwd;
      cur_i = ia; cur_d = da;
      @(negedge CLK);
      if (model_idle) begin
        n_cmp++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin n_bad++;
          $display("FAIL rnd_idle_strobe cyc%0d: got r=%b w=%b, expected 0 0", cyc, MEM_READ, MEM_WRITE); end
        n_cmp++; if (I_BUSYWAIT !== cur_i || D_BUSYWAIT !== cur_d || I_READDATA !== '0 || D_READDATA !== '0) begin n_bad++;
          $display("FAIL rnd_idle_out cyc%0d: got ibw=%b dbw=%b, expected %b %b", cyc, I_BUSYWAIT, D_BUSYWAIT, cur_i, cur_d); end
        if (cur_i || cur_d) begin
          own_d = cur_d && (!cur_i || !last_d);
          last_d = own_d;
          model_idle = 0;
        end
      end else begin
        complete = (MEM_BUSYWAIT === 1'b0);
        if (own_d) begin
          exp_rd = (complete && !dw) ? gold[da_addr[7:0]] : '0;
          n_cmp++; if (MEM_WRITE !== dw || MEM_READ !== !dw || MEM_ADDRESS !== da_addr || (dw && MEM_WRITEDATA !== dwd)) begin n_bad++;
            $display("FAIL rnd_dmem cyc%0d: got w=%b r=%b addr=%h, expected w=%b addr=%h", cyc, MEM_WRITE, MEM_READ, MEM_ADDRESS, dw, da_addr); end
          n_cmp++; if (D_BUSYWAIT !== !complete || I_BUSYWAIT !== cur_i) begin n_bad++;
            $display("FAIL rnd_dbusy cyc%0d: got dbw=%b ibw=%b, expected %b %b", cyc, D_BUSYWAIT, I_BUSYWAIT, !complete, cur_i); end
          n_cmp++; if (D_READDATA !== exp_rd || I_READDATA !== '0) begin n_bad++;
            $display("FAIL rnd_drdata cyc%0d: got d=%h i=%h, expected d=%h", cyc, D_READDATA, I_READDATA, exp_rd); end
          if (complete) begin
            if (dw) gold[da_addr[7:0]] = dwd;
            da = 0; dgap = $urandom_range(1, 3);
          end
        end else begin
          exp_rd = complete ? gold[ia_addr[7:0]] : '0;
          n_cmp++; if (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0 || MEM_ADDRESS !== ia_addr) begin n_bad++;
            $display("FAIL rnd_imem cyc%0d: got r=%b w=%b addr=%h, expected 1 0 %h", cyc, MEM_READ, MEM_WRITE, MEM_ADDRESS, ia_addr); end
          n_cmp++; if (I_BUSYWAIT !== !complete || D_BUSYWAIT !== cur_d) begin n_bad++;
            $display("FAIL rnd_ibusy cyc%0d: got ibw=%b dbw=%b, expected %b %b", cyc, I_BUSYWAIT, D_BUSYWAIT, !complete, cur_d); end
          n_cmp++; if (I_READDATA !== exp_rd || D_READDATA !== '0) begin n_bad++;
            $display("FAIL rnd_irdata cyc%0d: got i=%h d=%h, expected i=%h", cyc, I_READDATA, D_READDATA, exp_rd); end
          if (complete) begin ia = 0; igap = $urandom_range(1, 3); end
        end
        if (complete) begin model_idle = 1; xfers++; end
      end
    end
    n_cmp++; if (xfers < 60) begin n_bad++;
      $display("FAIL rnd_timeout: got %0d transfers expected 60", xfers); end
    @(posedge CLK); #1; idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) gold[i] = init_val(8'(i));
    test_reset();
    test_single_read();
    test_contend();
    test_alternation();
    test_addr_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
